string_fifo_arbiter: RTL and testbench

Two-port arbiter that shares the single string FIFO Avalon-MM slave (FIFO data at address 0, fill count at address 2) between two requesters, e.g. the NIOS II bridge and a string-processing engine. It uses round-robin priority with an optional lock, so one requester can push or pop a whole multi-word string atomically. A MAX_HOLD watchdog bounds how long a lock may starve the other port. The arbiter drives the slave's chipselect/address/read/write/writedata directly and returns readdata to the granted requester.

---
 rtl/string_fifo_arbiter.sv | 151 +++++++++++++++
 tb/tb_string_fifo_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/string_fifo_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : string_fifo_arbiter                                           |
// | Brief    : Two-port round-robin arbiter with lock and hold watchdog that |
// |            shares one string FIFO Avalon-MM slave between requesters.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module string_fifo_arbiter #(
  parameter int DW       = 32,
  parameter int AW       = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  // port 0
  input  logic          req0,
  input  logic          lock0,
  input  logic          rd0,
  input  logic          wr0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  // port 1
  input  logic          req1,
  input  logic          lock1,
  input  logic          rd1,
  input  logic          wr1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  // shared FIFO slave
  output logic          chipselect,
  output logic          read,
  output logic          write,
  output logic [AW-1:0] address,
  output logic [DW-1:0] writedata,
  input  logic [DW-1:0] readdata
);

  // Hold counter only needs to reach MAX_HOLD-1; keep at least one bit.
  localparam int              c_cw       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [c_cw-1:0] c_hold_max = c_cw'(MAX_HOLD - 1);

  // OWN0/OWN1 are one-hot bits so each grant is a plain flop output.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } state_t;

  state_t          r_state;
  logic            r_ptr;     // port favoured when both request from IDLE
  logic [c_cw-1:0] r_hold;    // OWN cycles in the current tenure, saturating

  logic            w_own0;
  logic            w_own1;
  logic            w_acc;
  logic            w_sel_rd;
  logic            w_sel_wr;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_wdata;
  logic            w_req_oth;
  logic            w_lock_own;
  logic            w_release;

  assign w_own0 = (r_state == ST_OWN0);
  assign w_own1 = (r_state == ST_OWN1);

  // Access happens only while the owner is actually requesting.
  assign w_acc = (w_own0 & req0) | (w_own1 & req1);

  // Select the owner's request fields; port 0 fields are the default.
  always_comb begin
    w_sel_rd    = rd0;
    w_sel_wr    = wr0;
    w_sel_addr  = addr0;
    w_sel_wdata = wdata0;
    w_req_oth   = req1;
    w_lock_own  = lock0;
    if (w_own1) begin
      w_sel_rd    = rd1;
      w_sel_wr    = wr1;
      w_sel_addr  = addr1;
      w_sel_wdata = wdata1;
      w_req_oth   = req0;
      w_lock_own  = lock1;
    end
  end

  // Release when unlocked, or when the watchdog expires with the other port waiting.
  assign w_release = ~w_lock_own | ((r_hold == c_hold_max) & w_req_oth);

  // Grants come straight from the state flops; everything else is decoded from them.
  assign gnt0       = w_own0;
  assign gnt1       = w_own1;
  assign ack0       = w_own0 & req0;
  assign ack1       = w_own1 & req1;
  assign chipselect = w_acc;
  assign write      = w_acc & w_sel_wr;
  assign read       = w_acc & w_sel_rd & ~w_sel_wr;   // write wins over read
  assign address    = w_acc ? w_sel_addr  : '0;
  assign writedata  = w_acc ? w_sel_wdata : '0;
  assign rdata0     = ack0  ? readdata    : '0;
  assign rdata1     = ack1  ? readdata    : '0;

  // Ownership FSM with round-robin pointer and hold watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= 1'b0;
      r_hold  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_hold <= '0;
          if (req0 & req1) begin
            r_state <= r_ptr ? ST_OWN1 : ST_OWN0;
          end else if (req1) begin
            r_state <= ST_OWN1;
          end else if (req0) begin
            r_state <= ST_OWN0;
          end
        end
        ST_OWN0, ST_OWN1: begin
          if (w_release) begin
            // Hand the pointer to the other port; zero-bubble handoff if it waits.
            r_ptr  <= ~w_own1;
            r_hold <= '0;
            if (w_req_oth) begin
              r_state <= w_own1 ? ST_OWN0 : ST_OWN1;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (r_hold != c_hold_max) begin
            r_hold <= r_hold + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_hold  <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_string_fifo_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_string_fifo_arbiter                                        |
// | Brief    : Self-checking bench for string_fifo_arbiter with a FIFO slave |
// |            model and a cycle-level behavioural arbiter reference.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_string_fifo_arbiter;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0, req1, lock0, lock1, rd0, rd1, wr0, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic          chipselect, read, write;
  logic [AW-1:0] address;
  logic [DW-1:0] writedata, readdata;

  int total = 0;
  int bad   = 0;

  string_fifo_arbiter #(.DW(DW), .AW(AW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .lock0(lock0), .rd0(rd0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .lock1(lock1), .rd1(rd1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .ack1(ack1), .rdata1(rdata1),
    .chipselect(chipselect), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata)
  );

  always #5 clk = ~clk;

  // FIFO slave: data at address 0, fill count at address 2, depth 64.
  logic [DW-1:0] mem [0:63];
  logic [5:0]    rp  = '0;
  logic [5:0]    wp  = '0;
  logic [6:0]    cnt = '0;

  assign readdata = (address == 3'd0) ? ((cnt != 7'd0) ? mem[rp] : '0) :
                    (address == 3'd2) ? DW'(cnt) : '0;

  // Slave commits writes and pops on the rising edge ending the access.
  always @(posedge clk) begin
    if (chipselect && write && address == 3'd0 && cnt != 7'd64) begin
      mem[wp] <= writedata;
      wp      <= wp + 6'd1;
      cnt     <= cnt + 7'd1;
    end else if (chipselect && read && address == 3'd0 && cnt != 7'd0) begin
      rp  <= rp + 6'd1;
      cnt <= cnt - 7'd1;
    end
  end

  // Reference: owner (-1 none), round-robin favourite, cycles held, FIFO contents.
  int            m_own = -1;
  int            m_ptr = 0;
  int            m_cyc = 0;
  logic [DW-1:0] sb [$];
  logic          e_ack0 = 1'b0;
  logic          e_ack1 = 1'b0;
  bit            pend0, pend1;
  logic [6:0]    saved_cnt;
  logic [DW-1:0] words [3];

  task automatic chk1(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_ptr = 0; m_cyc = 0;
  endtask

  // Compare all outputs against the reference, then advance the reference one cycle.
  task automatic check_cycle(input string tag);
    logic          rq, r, w, oreq, lk;
    logic [AW-1:0] a;
    logic [DW-1:0] d, erdv;
    logic          acc;
    int            other;
    rq = 1'b0; r = 1'b0; w = 1'b0; a = '0; d = '0;
    if (m_own == 0) begin rq = req0; r = rd0; w = wr0; a = addr0; d = wdata0; end
    if (m_own == 1) begin rq = req1; r = rd1; w = wr1; a = addr1; d = wdata1; end
    acc    = rq;
    e_ack0 = (m_own == 0) && req0;
    e_ack1 = (m_own == 1) && req1;
    if (a == 3'd0)      erdv = (sb.size() > 0) ? sb[0] : '0;
    else if (a == 3'd2) erdv = DW'(sb.size());
    else                erdv = '0;
    chk1({tag, ".gnt0"}, gnt0, m_own == 0);
    chk1({tag, ".gnt1"}, gnt1, m_own == 1);
    chk1({tag, ".ack0"}, ack0, e_ack0);
    chk1({tag, ".ack1"}, ack1, e_ack1);
    chk1({tag, ".cs"},   chipselect, acc);
    chk1({tag, ".wr"},   write, acc && w);
    chk1({tag, ".rd"},   read, acc && r && !w);
    chkw({tag, ".addr"}, DW'(address), acc ? DW'(a) : '0);
    chkw({tag, ".wd"},   writedata, acc ? d : '0);
    chkw({tag, ".rd0"},  rdata0, e_ack0 ? erdv : '0);
    chkw({tag, ".rd1"},  rdata1, e_ack1 ? erdv : '0);
    if (acc && w && a == 3'd0) begin
      if (sb.size() < 64) sb.push_back(d);
    end else if (acc && r && a == 3'd0) begin
      if (sb.size() > 0) void'(sb.pop_front());
    end
    if (m_own < 0) begin
      if (req0 && req1)  m_own = m_ptr;
      else if (req0)     m_own = 0;
      else if (req1)     m_own = 1;
      m_cyc = 0;
    end else begin
      other = 1 - m_own;
      oreq  = (other == 1) ? req1 : req0;
      lk    = (m_own == 1) ? lock1 : lock0;
      m_cyc++;
      if (!lk || (m_cyc >= MH && oreq)) begin
        m_ptr = other;
        m_own = oreq ? other : -1;
        m_cyc = 0;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk1({tag, ".gnt0"}, gnt0, 1'b0);
    chk1({tag, ".gnt1"}, gnt1, 1'b0);
    chk1({tag, ".ack0"}, ack0, 1'b0);
    chk1({tag, ".ack1"}, ack1, 1'b0);
    chk1({tag, ".cs"},   chipselect, 1'b0);
    chk1({tag, ".wr"},   write, 1'b0);
    chk1({tag, ".rd"},   read, 1'b0);
    chkw({tag, ".addr"}, DW'(address), '0);
    chkw({tag, ".wd"},   writedata, '0);
    chkw({tag, ".rd0"},  rdata0, '0);
    chkw({tag, ".rd1"},  rdata1, '0);
  endtask

  task automatic samp(input string tag);
    @(negedge clk);
    check_cycle(tag);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; lock0 = 0; rd0 = 0; wr0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; lock1 = 0; rd1 = 0; wr1 = 0; addr1 = '0; wdata1 = '0;
  endtask

  task automatic rand_req(output logic r, output logic w, output logic [AW-1:0] a,
                          output logic [DW-1:0] d, output logic l);
    int kind, sel;
    kind = int'($urandom_range(0, 3));
    sel  = int'($urandom_range(0, 4));
    w = (kind <= 1);
    r = (kind == 2) || ((kind <= 1) && ($urandom_range(0, 1) == 1));
    a = (sel <= 2) ? 3'd0 : (sel == 3) ? 3'd2 : AW'($urandom_range(0, 7));
    d = $urandom;
    l = ($urandom_range(0, 3) == 0);
  endtask

  // Port 1 keeps reading address 0 until the reference FIFO is empty.
  task automatic pop_all();
    req0 = 0; lock0 = 0; rd0 = 0; wr0 = 0;
    req1 = 1; rd1 = 1; wr1 = 0; addr1 = 3'd0; lock1 = 0;
    for (int k = 0; k < 200 && sb.size() != 0; k++) begin
      samp("pop"); adv();
    end
    req1 = 0; rd1 = 0;
    samp("pop_end"); adv();
    samp("pop_end"); adv();
  endtask

  initial begin
    words[0] = 32'h61626364; words[1] = 32'h31323334; words[2] = 32'h35363738;
    idle_inputs();
    rst_n = 0;

    // Reset held with random inputs: every output must be zero.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      req0 = 1'($urandom); lock0 = 1'($urandom); rd0 = 1'($urandom); wr0 = 1'($urandom);
      req1 = 1'($urandom); lock1 = 1'($urandom); rd1 = 1'($urandom); wr1 = 1'($urandom);
      addr0 = AW'($urandom); addr1 = AW'($urandom); wdata0 = $urandom; wdata1 = $urandom;
      #2;
      check_zero("rst");
    end
    idle_inputs();
    rst_n = 1;
    model_reset();
    adv();
    for (int i = 0; i < 3; i++) begin samp("idle"); adv(); end

    // Both requesting unlocked: strict alternation, port 0 first.
    req0 = 1; wr0 = 1; rd0 = 0; addr0 = 3'd0; wdata0 = 32'h41424344; lock0 = 0;
    req1 = 1; rd1 = 1; wr1 = 0; addr1 = 3'd2; lock1 = 0;
    samp("alt_idle"); chk1("alt_idle_gnt", gnt0 | gnt1, 1'b0); adv();
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 1) wdata0 = 32'h30303030 + DW'(i);
      samp("alt");
      chk1("alt_ack0", ack0, (i % 2) == 0);
      chk1("alt_ack1", ack1, (i % 2) == 1);
      adv();
    end
    req0 = 0; req1 = 0; wr0 = 0; rd1 = 0;
    samp("alt_end"); adv();
    samp("alt_end"); adv();
    pop_all();

    // Single unlocked write of "abcd".
    req0 = 1; wr0 = 1; rd0 = 0; addr0 = 3'd0; wdata0 = 32'h61626364; lock0 = 0;
    samp("w1_idle"); chk1("w1_idle_gnt0", gnt0, 1'b0); adv();
    samp("w1");
    chk1("w1_gnt0", gnt0, 1'b1); chk1("w1_ack0", ack0, 1'b1);
    chk1("w1_cs", chipselect, 1'b1); chk1("w1_write", write, 1'b1);
    chkw("w1_addr", DW'(address), '0); chkw("w1_wdata", writedata, 32'h61626364);
    adv();
    req0 = 0; wr0 = 0;
    samp("w1_after"); chk1("w1_after_gnt0", gnt0, 1'b0); adv();
    pop_all();

    // Atomic three-word string under lock; port 1 reads the count afterwards.
    req0 = 1; wr0 = 1; rd0 = 0; addr0 = 3'd0; lock0 = 1; wdata0 = words[0];
    req1 = 1; rd1 = 1; wr1 = 0; addr1 = 3'd2; lock1 = 0;
    samp("at_idle"); adv();
    for (int i = 0; i < 3; i++) begin
      wdata0 = words[i];
      lock0  = (i != 2);
      samp("at");
      chk1("at_ack0", ack0, 1'b1);
      chk1("at_ack1", ack1, 1'b0);
      adv();
    end
    req0 = 0; wr0 = 0; lock0 = 0;
    samp("at_r1");
    chk1("at_r1_ack1", ack1, 1'b1);
    chkw("at_r1_count", rdata1, 32'd3);
    adv();
    req1 = 0; rd1 = 0;
    samp("at_end"); adv();
    pop_all();

    // Watchdog: locked port 0 gets exactly MH accesses, then port 1, then back.
    req0 = 1; wr0 = 1; rd0 = 0; addr0 = 3'd0; lock0 = 1; wdata0 = 32'hAAAA0000;
    req1 = 1; rd1 = 1; wr1 = 0; addr1 = 3'd2; lock1 = 0;
    samp("wd_idle"); adv();
    for (int i = 0; i < MH; i++) begin
      wdata0 = 32'hAAAA0000 + DW'(i);
      samp("wd");
      chk1("wd_ack0", ack0, 1'b1);
      chk1("wd_ack1", ack1, 1'b0);
      adv();
    end
    samp("wd_hand");
    chk1("wd_gnt1", gnt1, 1'b1); chk1("wd_ack1_hand", ack1, 1'b1); chk1("wd_ack0_hand", ack0, 1'b0);
    adv();
    req1 = 0; rd1 = 0;
    samp("wd_back"); chk1("wd_back_gnt0", gnt0, 1'b1); chk1("wd_back_ack0", ack0, 1'b1); adv();
    req0 = 0; lock0 = 0; wr0 = 0;
    samp("wd_end"); adv();
    pop_all();

    // Reset asserted mid-lock while port 0 is writing.
    req0 = 1; wr0 = 1; rd0 = 0; addr0 = 3'd0; lock0 = 1; wdata0 = 32'hDEAD0001;
    samp("rm_idle0"); adv();
    samp("rm_own"); chk1("rm_own_write", write, 1'b1); adv();
    wdata0 = 32'hDEAD0002;
    saved_cnt = cnt;
    #1 rst_n = 0;
    #1;
    chk1("rm_gnt0", gnt0, 1'b0); chk1("rm_ack0", ack0, 1'b0);
    chk1("rm_write", write, 1'b0); chk1("rm_cs", chipselect, 1'b0);
    model_reset();
    adv();
    chkw("rm_count", DW'(cnt), DW'(saved_cnt));
    req0 = 0; lock0 = 0; wr0 = 0;
    req1 = 1; rd1 = 1; wr1 = 0; addr1 = 3'd2; lock1 = 0;
    rst_n = 1;
    samp("rm_req1"); chk1("rm_req1_gnt1", gnt1, 1'b0); adv();
    samp("rm_gnt"); chk1("rm_gnt1", gnt1, 1'b1); chk1("rm_ack1", ack1, 1'b1); adv();
    req1 = 0; rd1 = 0;
    samp("rm_end"); adv();
    pop_all();

    // Random traffic from both requesters against the reference.
    pend0 = 0; pend1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pend0) begin
        if ($urandom_range(0, 2) != 0) begin
          rand_req(rd0, wr0, addr0, wdata0, lock0); req0 = 1; pend0 = 1;
        end else begin
          req0 = 0; lock0 = 1'($urandom_range(0, 1));
        end
      end
      if (!pend1) begin
        if ($urandom_range(0, 2) != 0) begin
          rand_req(rd1, wr1, addr1, wdata1, lock1); req1 = 1; pend1 = 1;
        end else begin
          req1 = 0; lock1 = 1'($urandom_range(0, 1));
        end
      end
      samp("rand");
      adv();
      if (e_ack0) pend0 = 0;
      if (e_ack1) pend1 = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
